// File: rtl/player2_src_ctrl.sv
// Player-2 source controller.
// Decides whether the player-2 ball/paddle sources come from the UART link
// or from local logic. A debounced board switch requests remote play, and
// link health is judged one video frame at a time. The mux select only moves
// on a frame boundary, so the source never switches in the middle of a frame.
module player2_src_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int ARM_FRAMES      = 4,
    parameter int TIMEOUT_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_raw,
    input  logic       frame_start,
    input  logic       uart_pkt_valid,
    input  logic       uart_pkt_err,
    output logic       sel_uart,
    output logic       link_ok,
    output logic [1:0] state,
    output logic [7:0] err_cnt
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GOOD_W = $clog2(ARM_FRAMES + 1);
    localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

    // Terminal values: reaching these on the current event completes the run.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(ARM_FRAMES - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_LOCAL  = 2'b00,
        ST_ARM    = 2'b01,
        ST_REMOTE = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    // Switch synchronizer and debouncer
    logic            sync1_reg;
    logic            sync2_reg;
    logic            sw_db_reg;
    logic [DB_W-1:0] db_cnt_reg;

    // Per-frame link observations
    logic pkt_seen_reg;
    logic err_seen_reg;
    logic frame_clean;
    logic frame_missed;

    // Control state
    state_t            state_reg;
    logic [GOOD_W-1:0] good_cnt_reg;
    logic [MISS_W-1:0] miss_cnt_reg;
    logic              leave_pend_reg;
    logic              sel_uart_reg;
    logic              link_ok_reg;
    logic [7:0]        err_cnt_reg;

    // A switch-off is acted on at the frame boundary whether it arrived
    // earlier in the frame or on the boundary cycle itself.
    logic leave_now;

    assign frame_clean  = pkt_seen_reg & ~err_seen_reg;
    assign frame_missed = ~pkt_seen_reg;
    assign leave_now    = leave_pend_reg | ~sw_db_reg;

    assign sel_uart = sel_uart_reg;
    assign link_ok  = link_ok_reg;
    assign state    = state_reg;
    assign err_cnt  = err_cnt_reg;

    // Two-flop synchronizer bringing the board switch into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= sw_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce: flip sw_db only after an unbroken run of mismatching samples;
    // any matching sample restarts the run from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_db_reg  <= 1'b0;
            db_cnt_reg <= '0;
        end else if (sync2_reg != sw_db_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                sw_db_reg  <= sync2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end else begin
            db_cnt_reg <= '0;
        end
    end

    // Frame flags: accumulate pulses during a frame; on frame_start the old
    // contents are consumed by the FSM and the flags restart from any pulse
    // coincident with that frame_start, which belongs to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_seen_reg <= 1'b0;
            err_seen_reg <= 1'b0;
        end else if (frame_start) begin
            pkt_seen_reg <= uart_pkt_valid;
            err_seen_reg <= uart_pkt_err;
        end else begin
            pkt_seen_reg <= pkt_seen_reg | uart_pkt_valid;
            err_seen_reg <= err_seen_reg | uart_pkt_err;
        end
    end

    // Saturating error counter, independent of the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= 8'd0;
        end else if (uart_pkt_err && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    // Source-selection FSM with registered mux select and link status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_LOCAL;
            good_cnt_reg   <= '0;
            miss_cnt_reg   <= '0;
            leave_pend_reg <= 1'b0;
            sel_uart_reg   <= 1'b0;
            link_ok_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOCAL: begin
                    sel_uart_reg <= 1'b0;
                    link_ok_reg  <= 1'b0;
                    if (sw_db_reg) begin
                        state_reg    <= ST_ARM;
                        good_cnt_reg <= '0;
                    end
                end

                ST_ARM: begin
                    sel_uart_reg <= 1'b0;
                    link_ok_reg  <= 1'b0;
                    if (!sw_db_reg) begin
                        // Not yet driving from UART, so back out right away.
                        state_reg <= ST_LOCAL;
                    end else if (frame_start) begin
                        if (frame_clean) begin
                            if (good_cnt_reg == GOOD_LAST) begin
                                state_reg      <= ST_REMOTE;
                                good_cnt_reg   <= '0;
                                miss_cnt_reg   <= '0;
                                leave_pend_reg <= 1'b0;
                                sel_uart_reg   <= 1'b1;
                                link_ok_reg    <= 1'b1;
                            end else begin
                                good_cnt_reg <= good_cnt_reg + 1'b1;
                            end
                        end else begin
                            good_cnt_reg <= '0;
                        end
                    end
                end

                ST_REMOTE: begin
                    if (!sw_db_reg) begin
                        leave_pend_reg <= 1'b1;
                    end
                    if (frame_start) begin
                        if (leave_now) begin
                            // Switch-off wins over a simultaneous timeout.
                            state_reg      <= ST_LOCAL;
                            leave_pend_reg <= 1'b0;
                            miss_cnt_reg   <= '0;
                            sel_uart_reg   <= 1'b0;
                            link_ok_reg    <= 1'b0;
                        end else if (frame_missed) begin
                            if (miss_cnt_reg == MISS_LAST) begin
                                state_reg    <= ST_HOLD;
                                miss_cnt_reg <= '0;
                                sel_uart_reg <= 1'b0;
                                link_ok_reg  <= 1'b0;
                            end else begin
                                miss_cnt_reg <= miss_cnt_reg + 1'b1;
                            end
                        end else begin
                            miss_cnt_reg <= '0;
                        end
                    end
                end

                ST_HOLD: begin
                    sel_uart_reg <= 1'b0;
                    link_ok_reg  <= 1'b0;
                    if (!sw_db_reg) begin
                        state_reg <= ST_LOCAL;
                    end else if (uart_pkt_valid) begin
                        state_reg    <= ST_ARM;
                        good_cnt_reg <= '0;
                    end
                end

                default: begin
                    state_reg    <= ST_LOCAL;
                    sel_uart_reg <= 1'b0;
                    link_ok_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player2_src_ctrl.sv
// Testbench for player2_src_ctrl.
// A frame-level reference model predicts the outputs after every clock edge
// and queues them; an independent monitor pops and compares each cycle.
module tb_player2_src_ctrl;

    localparam int DB_CYC  = 4;
    localparam int ARM_FR  = 2;
    localparam int TOUT_FR = 3;

    localparam int S_LOCAL  = 0;
    localparam int S_ARM    = 1;
    localparam int S_REMOTE = 2;
    localparam int S_HOLD   = 3;

    logic       clk;
    logic       rst;
    logic       sw_raw;
    logic       frame_start;
    logic       uart_pkt_valid;
    logic       uart_pkt_err;
    logic       sel_uart;
    logic       link_ok;
    logic [1:0] state;
    logic [7:0] err_cnt;

    player2_src_ctrl #(
        .DEBOUNCE_CYCLES(DB_CYC),
        .ARM_FRAMES     (ARM_FR),
        .TIMEOUT_FRAMES (TOUT_FR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_raw        (sw_raw),
        .frame_start   (frame_start),
        .uart_pkt_valid(uart_pkt_valid),
        .uart_pkt_err  (uart_pkt_err),
        .sel_uart      (sel_uart),
        .link_ok       (link_ok),
        .state         (state),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       sel;
        logic       link;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic sw_level = 1'b0;

    // Reference model state (frame-level view)
    int m_state;
    int m_db;
    int m_run;
    int m_hist[$];
    int m_pkts;
    int m_errs;
    int m_clean_run;
    int m_miss_run;
    int m_leave;
    int m_err;

    task automatic model_reset();
        m_state     = S_LOCAL;
        m_db        = 0;
        m_run       = 0;
        m_hist      = '{0, 0};
        m_pkts      = 0;
        m_errs      = 0;
        m_clean_run = 0;
        m_miss_run  = 0;
        m_leave     = 0;
        m_err       = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        exp_t e;
        int   synced;
        bit   clean;
        bit   missed;
        if (rst) begin
            model_reset();
        end else begin
            clean  = 1'b0;
            missed = 1'b0;
            if (frame_start) begin
                clean  = (m_pkts > 0) && (m_errs == 0);
                missed = (m_pkts == 0);
                m_pkts = int'(uart_pkt_valid);
                m_errs = int'(uart_pkt_err);
            end else begin
                m_pkts += int'(uart_pkt_valid);
                m_errs += int'(uart_pkt_err);
            end
            case (m_state)
                S_LOCAL: if (m_db != 0) begin
                    m_state     = S_ARM;
                    m_clean_run = 0;
                end
                S_ARM: begin
                    if (m_db == 0) m_state = S_LOCAL;
                    else if (frame_start) begin
                        m_clean_run = clean ? m_clean_run + 1 : 0;
                        if (m_clean_run == ARM_FR) begin
                            m_state    = S_REMOTE;
                            m_miss_run = 0;
                            m_leave    = 0;
                        end
                    end
                end
                S_REMOTE: begin
                    if (m_db == 0) m_leave = 1;
                    if (frame_start) begin
                        if (m_leave != 0) m_state = S_LOCAL;
                        else begin
                            m_miss_run = missed ? m_miss_run + 1 : 0;
                            if (m_miss_run == TOUT_FR) m_state = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (m_db == 0) m_state = S_LOCAL;
                    else if (uart_pkt_valid) begin
                        m_state     = S_ARM;
                        m_clean_run = 0;
                    end
                end
            endcase
            if (uart_pkt_err && m_err < 255) m_err++;
            // Switch path: the value seen this edge was sampled two edges ago.
            synced = m_hist[m_hist.size() - 2];
            if (synced != m_db) m_run++;
            else m_run = 0;
            if (m_run == DB_CYC) begin
                m_db  = (m_db == 0) ? 1 : 0;
                m_run = 0;
            end
            m_hist.push_back(int'(sw_raw));
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
        e.st   = 2'(m_state);
        e.sel  = (m_state == S_REMOTE);
        e.link = (m_state == S_REMOTE);
        e.ec   = 8'(m_err);
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus: drive on the falling edge, model on the rising edge.
    task automatic tick(input logic r, input logic fs, input logic pv, input logic pe);
        @(negedge clk);
        rst            = r;
        frame_start    = fs;
        uart_pkt_valid = pv;
        uart_pkt_err   = pe;
        sw_raw         = sw_level;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // A frame of len cycles: frame_start first, optional pkt at cycle 2, error at cycle 4.
    task automatic frame(input int len, input bit pkt, input bit err);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < len; i++)
            tick(1'b0, 1'b0, (pkt && i == 2), (err && i == 4));
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",    {6'd0, state},    {6'd0, e.st});
                check("sel_uart", {7'd0, sel_uart}, {7'd0, e.sel});
                check("link_ok",  {7'd0, link_ok},  {7'd0, e.link});
                check("err_cnt",  err_cnt,          e.ec);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        int flen;
        int fpos;
        int sw_hold;
        int pkt_div;
        rst = 1'b1; sw_raw = 1'b0; frame_start = 1'b0;
        uart_pkt_valid = 1'b0; uart_pkt_err = 1'b0;
        model_reset();

        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        $display("phase reset done");

        // Bouncing switch: 3 high, 1 low, then stays high.
        sw_level = 1'b1; idle(3);
        sw_level = 1'b0; idle(1);
        sw_level = 1'b1; idle(10);
        $display("phase bounce done");

        // Arming: an errored frame resets progress, then clean frames arm.
        frame(10, 1, 0);
        frame(10, 1, 1);
        frame(10, 1, 0);
        frame(10, 1, 0);
        frame(10, 1, 0);
        frame(10, 1, 0);
        $display("phase arm done");

        // Timeout into HOLD, then a packet re-arms and the link recovers.
        frame(10, 0, 0);
        frame(10, 0, 0);
        frame(10, 0, 0);
        frame(10, 0, 0);
        idle(3);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        frame(10, 1, 0);
        frame(10, 1, 0);
        frame(10, 1, 0);
        frame(10, 1, 0);
        $display("phase timeout done");

        // Switch-off mid-frame in REMOTE: held until the next frame_start.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        sw_level = 1'b0;
        idle(12);
        frame(10, 0, 0);
        $display("phase switch-off done");

        // Coincident packet: credited to the frame that is starting.
        sw_level = 1'b1; idle(10);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            idle(8);
        end
        $display("phase coincidence done");

        // Reset while REMOTE.
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        $display("phase mid-reset done");

        // Error saturation.
        for (int k = 0; k < 300; k++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        $display("phase errors done, err_cnt expected %0d", m_err);

        // Randomized run with varying link quality and switch activity.
        flen = 10; fpos = 0; sw_hold = 0; pkt_div = 4;
        for (int c = 0; c < 4000; c++) begin
            logic fs, pv, pe, r;
            if (c % 300 == 0) begin
                case ($urandom_range(0, 2))
                    0: pkt_div = 3;
                    1: pkt_div = 30;
                    default: pkt_div = 1000;
                endcase
            end
            if (sw_hold == 0) begin
                sw_level = ($urandom_range(0, 9) < 8);
                sw_hold  = $urandom_range(1, 60);
            end else begin
                sw_hold--;
            end
            fs = (fpos == 0);
            fpos = (fpos + 1 >= flen) ? 0 : fpos + 1;
            if (fs) flen = $urandom_range(6, 14);
            pv = ($urandom_range(0, pkt_div - 1) == 0);
            pe = ($urandom_range(0, 24) == 0);
            r  = ($urandom_range(0, 799) == 0);
            tick(r, fs, pv, pe);
        end
        $display("phase random done");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/player2_src_ctrl.md
PLAYER2_SRC_CTRL -- requirements
Module: player2_src_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 650000, cycles sw_raw must stay stable before the debounced switch changes.
REQ-002 Parameter ARM_FRAMES, default 4, consecutive clean UART frames required before remote control is granted.
REQ-003 Parameter TIMEOUT_FRAMES, default 8, consecutive frames without a UART packet before remote control is revoked.
REQ-004 Clock clk; reset rst, synchronous, active-high.
REQ-005 clk  input  1  system pixel clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 sw_raw  input  1  asynchronous board switch; 1 requests UART-driven player 2.
REQ-008 frame_start  input  1  one-cycle pulse at the start of each vertical blank.
REQ-009 uart_pkt_valid  input  1  one-cycle pulse when a complete ball and paddle packet has been received.
REQ-010 uart_pkt_err  input  1  one-cycle pulse on a UART framing or checksum error.
REQ-011 sel_uart  output  1  mux select; 1 selects UART ball and paddle sources, 0 selects local logic.
REQ-012 link_ok  output  1  1 only while in state REMOTE.
REQ-013 state  output  2  LOCAL=00, ARM=01, REMOTE=10, HOLD=11.
REQ-014 err_cnt  output  8  saturating count of uart_pkt_err pulses.

Function
REQ-015 sw_raw SHALL pass through a 2-flop synchronizer; sw_db SHALL toggle only after the synchronized value has differed from sw_db for DEBOUNCE_CYCLES consecutive cycles, and any mismatch gap SHALL restart the count.
REQ-016 Per-frame flags pkt_seen and err_seen SHALL be set by pulses between frame_start pulses and evaluated, then cleared, on each frame_start.
REQ-017 A pulse coincident with frame_start SHALL count toward the newly starting frame, not the frame being evaluated.
REQ-018 A frame is "clean" when pkt_seen=1 and err_seen=0; it is "missed" when pkt_seen=0.
REQ-019 LOCAL: sel_uart=0; sw_db=1 -> ARM with good_cnt cleared.
REQ-020 ARM: sel_uart=0; at each frame_start, good_cnt increments on a clean frame and otherwise clears.
REQ-021 ARM -> REMOTE on the frame_start at which good_cnt reaches ARM_FRAMES; sel_uart rises in the cycle after that frame_start.
REQ-022 ARM -> LOCAL immediately when sw_db=0.
REQ-023 REMOTE: sel_uart=1; at each frame_start, miss_cnt increments on a missed frame and otherwise clears; err_seen does not affect REMOTE.
REQ-024 REMOTE -> HOLD on the frame_start at which miss_cnt reaches TIMEOUT_FRAMES.
REQ-025 In REMOTE, sw_db=0 SHALL set leave_pend; the state SHALL move to LOCAL on the next frame_start.
REQ-026 sel_uart SHALL change only in the cycle following a frame_start pulse, so no mid-frame source switch occurs.
REQ-027 If timeout and leave_pend coincide on the same frame_start, the next state is LOCAL.
REQ-028 HOLD: sel_uart=0 and link_ok=0; sw_db=0 -> LOCAL; otherwise a uart_pkt_valid pulse -> ARM with good_cnt cleared.
REQ-029 err_cnt SHALL increment on every uart_pkt_err pulse in any state, saturate at 255, and clear only on rst.
REQ-030 All counters SHALL be sized to $clog2(parameter+1) bits and SHALL never wrap.

Reset
REQ-031 On rst: state=LOCAL, sel_uart=0, link_ok=0, err_cnt=0, sw_db=0, synchronizer=0, and all counters, flags and leave_pend cleared.
REQ-032 An rst asserted mid-operation SHALL override all other inputs and drop sel_uart in the next cycle, regardless of frame_start.

Verification
(All scenarios use DEBOUNCE_CYCLES=4, ARM_FRAMES=2, TIMEOUT_FRAMES=3.)
REQ-033 Bounce: sw_raw=1 for 3 cycles, 0 for 1 cycle, then 1 for 6 cycles -> sw_db=1 only after 4 stable cycles counted from the final rise plus synchronizer delay; state LOCAL->ARM.
REQ-034 Arm: sw=1, one pkt in each of 2 frames -> state=REMOTE and sel_uart=1 in the cycle after the 2nd evaluating frame_start; an error in a frame resets good_cnt.
REQ-035 Timeout: in REMOTE, no pkts for 3 frames -> state=HOLD, sel_uart=0 and link_ok=0 after the 3rd frame_start; a subsequent pkt -> ARM.
REQ-036 Switch-off: sw_db falls mid-frame in REMOTE -> sel_uart stays 1 until the next frame_start, then LOCAL with sel_uart=0.
REQ-037 Coincidence: pkt pulse on the same cycle as frame_start in ARM -> the pulse credits the next frame; a frame with only that coincident pulse is evaluated as clean.
REQ-038 Errors: 300 uart_pkt_err pulses -> err_cnt=255 and holds; rst mid-REMOTE -> all outputs at their reset values the next cycle.
